// File: rtl/ifq_fetch_ctrl_if.sv
// Signal bundle between the IFQ fetch sequencer, the I-cache request port and the IFQ.
// IFQ_CTRL_PERF_EN adds the two performance counter outputs.
interface ifq_fetch_ctrl_if #(
    parameter int OCC_W = 3
);
    // Handshake: a request transfers on every cycle where fetch_req and cache_ready are both high;
    // fetch_addr is stable while fetch_req is high, and cache_dout_valid returns the accepted line later.
    logic             jmp_branch_valid;
    logic [31:0]      jmp_branch_address;
    logic             cache_ready;
    logic             cache_dout_valid;
    logic             line_pop;
    logic             fetch_req;
    logic [31:0]      fetch_addr;
    logic             cache_abort;
    logic             ifq_wr_en;
    logic             ifq_flush;
    logic [1:0]       start_offset;
    logic [OCC_W-1:0] occupancy;
    logic             ifq_full;
    logic [1:0]       state_dbg;
`ifdef IFQ_CTRL_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_redirect_cnt;

    modport master (
        input  jmp_branch_valid, jmp_branch_address, cache_ready, cache_dout_valid, line_pop,
        output fetch_req, fetch_addr, cache_abort, ifq_wr_en, ifq_flush, start_offset,
        output occupancy, ifq_full, state_dbg, perf_stall_cnt, perf_redirect_cnt
    );
    modport slave (
        output jmp_branch_valid, jmp_branch_address, cache_ready, cache_dout_valid, line_pop,
        input  fetch_req, fetch_addr, cache_abort, ifq_wr_en, ifq_flush, start_offset,
        input  occupancy, ifq_full, state_dbg, perf_stall_cnt, perf_redirect_cnt
    );
`else
    modport master (
        input  jmp_branch_valid, jmp_branch_address, cache_ready, cache_dout_valid, line_pop,
        output fetch_req, fetch_addr, cache_abort, ifq_wr_en, ifq_flush, start_offset,
        output occupancy, ifq_full, state_dbg
    );
    modport slave (
        output jmp_branch_valid, jmp_branch_address, cache_ready, cache_dout_valid, line_pop,
        input  fetch_req, fetch_addr, cache_abort, ifq_wr_en, ifq_flush, start_offset,
        input  occupancy, ifq_full, state_dbg
    );
`endif
endinterface

// File: rtl/ifq_fetch_ctrl.sv
// Fetch sequencer: issues line-aligned I-cache requests with IFQ credit tracking and redirect flush.
// Optional IFQ_CTRL_PERF_EN adds saturating stall/redirect counters.
module ifq_fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    ifq_fetch_ctrl_if.master    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } state_t;

    localparam logic [31:0]      RESET_LINE = RESET_PC & ~32'hF;
    localparam logic [1:0]       RESET_SO   = RESET_PC[3:2];
    localparam logic [OCC_W-1:0] DEPTH_OCC  = OCC_W'(DEPTH);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       so_q, so_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             flush_q, abort_q, abort_d;
    logic             jmp, fill, pop_ok, req, accept;
    logic             unused_addr_bits;

    assign jmp    = bus.jmp_branch_valid;
    // Only one request is ever outstanding, and never while in REQ, so free space alone grants the credit.
    assign req    = (state_q == REQ) && (occ_q < DEPTH_OCC);
    assign accept = req && bus.cache_ready;
    assign fill   = (state_q == WAIT) && bus.cache_dout_valid && !jmp;
    assign pop_ok = bus.line_pop && (occ_q != '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        so_d    = so_q;
        abort_d = 1'b0;
        occ_d   = occ_q + OCC_W'(fill) - OCC_W'(pop_ok);
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (accept) state_d = WAIT;
            WAIT: if (fill) begin
                addr_d  = addr_q + 32'd16;
                state_d = (occ_d == DEPTH_OCC) ? FULL : REQ;
            end
            FULL: if (bus.line_pop) state_d = REQ;
            default: state_d = IDLE;
        endcase
        // A redirect wins over everything; a same-cycle fill completes the request, so nothing is aborted.
        if (jmp) begin
            state_d = REQ;
            occ_d   = '0;
            addr_d  = {bus.jmp_branch_address[31:4], 4'b0000};
            so_d    = bus.jmp_branch_address[3:2];
            abort_d = ((state_q == WAIT) && !bus.cache_dout_valid) || accept;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= RESET_LINE;
            so_q    <= RESET_SO;
            occ_q   <= '0;
            flush_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            so_q    <= so_d;
            occ_q   <= occ_d;
            flush_q <= jmp;
            abort_q <= abort_d;
        end
    end

    assign bus.fetch_req    = req;
    assign bus.fetch_addr   = addr_q;
    assign bus.cache_abort  = abort_q;
    assign bus.ifq_wr_en    = fill;
    assign bus.ifq_flush    = flush_q;
    assign bus.start_offset = so_q;
    assign bus.occupancy    = occ_q;
    assign bus.ifq_full     = (occ_q == DEPTH_OCC);
    assign bus.state_dbg    = state_q;
    assign unused_addr_bits = ^bus.jmp_branch_address[1:0];

`ifdef IFQ_CTRL_PERF_EN
    logic [31:0] stall_q, redir_q;
    logic        stall_evt;

    assign stall_evt = (state_q == FULL) || ((state_q == REQ) && !bus.cache_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (stall_evt && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (jmp && (redir_q != 32'hFFFF_FFFF)) redir_q <= redir_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt    = stall_q;
    assign bus.perf_redirect_cnt = redir_q;
`endif
endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Cycle-table bench for ifq_fetch_ctrl with a request-address scoreboard and
// hand-written async-reset sequence.
module tb_ifq_fetch_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FULL = 2'd3;

    typedef struct {
        logic        jmp;
        logic [31:0] jaddr;
        logic        rdy;
        logic        dv;
        logic        pop;
        logic        req;
        logic [31:0] addr;
        logic        wr;
        logic        flush;
        logic        abort;
        logic [2:0]  occ;
        logic        full;
        logic [1:0]  so;
        logic [1:0]  st;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    vec_t        tbl[$];

    ifq_fetch_ctrl_if #(.OCC_W(3)) bus ();

    ifq_fetch_ctrl #(
        .DEPTH    (4),
        .RESET_PC (32'h0040_0000)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic jmp, input logic [31:0] jaddr, input logic rdy,
                                input logic dv, input logic pop, input logic req,
                                input logic [31:0] addr, input logic wr, input logic flush,
                                input logic abort, input logic [2:0] occ, input logic full,
                                input logic [1:0] so, input logic [1:0] st);
        vec_t v;
        v.jmp = jmp; v.jaddr = jaddr; v.rdy = rdy; v.dv = dv; v.pop = pop;
        v.req = req; v.addr = addr; v.wr = wr; v.flush = flush; v.abort = abort;
        v.occ = occ; v.full = full; v.so = so; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " fetch_req"},    32'(bus.fetch_req),    32'(v.req));
        check({tag, " fetch_addr"},   bus.fetch_addr,        v.addr);
        check({tag, " ifq_wr_en"},    32'(bus.ifq_wr_en),    32'(v.wr));
        check({tag, " ifq_flush"},    32'(bus.ifq_flush),    32'(v.flush));
        check({tag, " cache_abort"},  32'(bus.cache_abort),  32'(v.abort));
        check({tag, " occupancy"},    32'(bus.occupancy),    32'(v.occ));
        check({tag, " ifq_full"},     32'(bus.ifq_full),     32'(v.full));
        check({tag, " start_offset"}, 32'(bus.start_offset), 32'(v.so));
        check({tag, " state"},        32'(bus.state_dbg),    32'(v.st));
    endtask

    // driver: called at a negedge, drives one cycle, samples #1 later, returns at next negedge
    task automatic step(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("r%0d", idx);
        bus.jmp_branch_valid   = v.jmp;
        bus.jmp_branch_address = v.jaddr;
        bus.cache_ready        = v.rdy;
        bus.cache_dout_valid   = v.dv;
        bus.line_pop           = v.pop;
        #1;
        check_outputs(tag, v);
        if (bus.fetch_req && bus.cache_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s sb_addr: got accept of %h expected no request", tag, bus.fetch_addr);
            end else begin
                check({tag, " sb_addr"}, bus.fetch_addr, exp_q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.jmp_branch_valid   = 1'b0;
        bus.jmp_branch_address = 32'h0;
        bus.cache_ready        = 1'b0;
        bus.cache_dout_valid   = 1'b0;
        bus.line_pop           = 1'b0;

        // scoreboard: every address the cache should see accepted, in order
        exp_q.push_back(32'h0040_0000); exp_q.push_back(32'h0040_0010);
        exp_q.push_back(32'h0040_0020); exp_q.push_back(32'h0040_0030);
        exp_q.push_back(32'h0040_0040); exp_q.push_back(32'h0040_1230);
        exp_q.push_back(32'h0040_2000); exp_q.push_back(32'h0040_2010);
        exp_q.push_back(32'h0040_2020); exp_q.push_back(32'h0040_3000);
        exp_q.push_back(32'hFFFF_FFF0); exp_q.push_back(32'h0000_0000);

        //             jmp jaddr          rdy dv pop  req addr           wr fl ab occ full so st
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, S_REQ));
        tbl.push_back(mk(0, 32'h0,          1, 1, 0,   0, 32'h0040_0000, 1, 0, 0, 0, 0, 0, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_0010, 0, 0, 0, 1, 0, 0, S_REQ));
        tbl.push_back(mk(0, 32'h0,          1, 1, 0,   0, 32'h0040_0010, 1, 0, 0, 1, 0, 0, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_0020, 0, 0, 0, 2, 0, 0, S_REQ));
        tbl.push_back(mk(0, 32'h0,          1, 1, 0,   0, 32'h0040_0020, 1, 0, 0, 2, 0, 0, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_0030, 0, 0, 0, 3, 0, 0, S_REQ));
        tbl.push_back(mk(0, 32'h0,          1, 1, 0,   0, 32'h0040_0030, 1, 0, 0, 3, 0, 0, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   0, 32'h0040_0040, 0, 0, 0, 4, 1, 0, S_FULL));
        tbl.push_back(mk(0, 32'h0,          1, 0, 1,   0, 32'h0040_0040, 0, 0, 0, 4, 1, 0, S_FULL));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_0040, 0, 0, 0, 3, 0, 0, S_REQ));
        tbl.push_back(mk(1, 32'h0040_1238,  0, 0, 0,   0, 32'h0040_0040, 0, 0, 0, 3, 0, 0, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          0, 0, 0,   1, 32'h0040_1230, 0, 1, 1, 0, 0, 2, S_REQ));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_1230, 0, 0, 0, 0, 0, 2, S_REQ));
        tbl.push_back(mk(1, 32'h0040_2004,  0, 1, 0,   0, 32'h0040_1230, 0, 0, 0, 0, 0, 2, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          0, 0, 1,   1, 32'h0040_2000, 0, 1, 0, 0, 0, 1, S_REQ));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_2000, 0, 0, 0, 0, 0, 1, S_REQ));
        tbl.push_back(mk(0, 32'h0,          0, 1, 0,   0, 32'h0040_2000, 1, 0, 0, 0, 0, 1, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_2010, 0, 0, 0, 1, 0, 1, S_REQ));
        tbl.push_back(mk(0, 32'h0,          0, 1, 0,   0, 32'h0040_2010, 1, 0, 0, 1, 0, 1, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0040_2020, 0, 0, 0, 2, 0, 1, S_REQ));
        tbl.push_back(mk(0, 32'h0,          0, 1, 1,   0, 32'h0040_2020, 1, 0, 0, 2, 0, 1, S_WAIT));
        tbl.push_back(mk(1, 32'h0040_3000,  0, 0, 0,   1, 32'h0040_2030, 0, 0, 0, 2, 0, 1, S_REQ));
        tbl.push_back(mk(1, 32'h0040_500C,  1, 0, 0,   1, 32'h0040_3000, 0, 1, 0, 0, 0, 0, S_REQ));
        tbl.push_back(mk(0, 32'h0,          0, 0, 0,   1, 32'h0040_5000, 0, 1, 1, 0, 0, 3, S_REQ));
        tbl.push_back(mk(1, 32'hFFFF_FFF0,  0, 0, 0,   1, 32'h0040_5000, 0, 0, 0, 0, 0, 3, S_REQ));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'hFFFF_FFF0, 0, 1, 0, 0, 0, 0, S_REQ));
        tbl.push_back(mk(0, 32'h0,          0, 1, 0,   0, 32'hFFFF_FFF0, 1, 0, 0, 0, 0, 0, S_WAIT));
        tbl.push_back(mk(0, 32'h0,          0, 0, 0,   1, 32'h0000_0000, 0, 0, 0, 1, 0, 0, S_REQ));
        tbl.push_back(mk(0, 32'h0,          1, 0, 0,   1, 32'h0000_0000, 0, 0, 0, 1, 0, 0, S_REQ));

        // reset state while reset is held
        repeat (2) @(negedge clk);
        bus.cache_dout_valid = 1'b1;
        #1;
        check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, S_IDLE));
        bus.cache_dout_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

        // async reset asserted in the middle of a WAIT cycle
        bus.jmp_branch_valid = 1'b0;
        bus.cache_ready      = 1'b0;
        bus.cache_dout_valid = 1'b1;
        bus.line_pop         = 1'b0;
        #1;
        check("mid_wait state", 32'(bus.state_dbg), 32'(S_WAIT));
        check("mid_wait ifq_wr_en", 32'(bus.ifq_wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", mk(0, 0, 0, 1, 0, 0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, S_IDLE));
        @(negedge clk);
        bus.cache_dout_valid = 1'b0;
        rst_n = 1'b1;
        step(100, mk(0, 32'h0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, S_IDLE));
        step(101, mk(0, 32'h0, 0, 0, 0, 1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, S_REQ));

        check("sb_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ifq_fetch_ctrl.md
Name: ifq_fetch_ctrl

Overview:
Fetch sequencer for the instruction fetch queue (IFQ).
- Issues line-aligned 128-bit cache line requests.
- Tracks queue occupancy plus the one outstanding request as credits, so the IFQ never overflows.
- On a jump/branch redirect: flushes the IFQ, cancels any in-flight cache access and restarts fetch at the target line.
- Sits between the I-cache request port and the IFQ write/flush inputs.

Parameters:
DEPTH, 4, IFQ capacity in 128-bit lines.
RESET_PC, 32'h0040_0000, first fetch address after reset; bits [3:0] are forced to 0.
OCC_W, $clog2(DEPTH+1), width of occupancy.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
jmp_branch_valid  in  1  redirect request, one-cycle pulse
jmp_branch_address  in  32  redirect target; bits [1:0] ignored
cache_ready  in  1  cache accepts a request this cycle
cache_dout_valid  in  1  requested line returned this cycle
line_pop  in  1  IFQ retired its oldest line
fetch_req  out  1  request valid
fetch_addr  out  32  line address of the request, bits [3:0]=0
cache_abort  out  1  cancel in-flight request, one-cycle pulse
ifq_wr_en  out  1  write the returned line into the IFQ
ifq_flush  out  1  clear the IFQ, one-cycle pulse
start_offset  out  2  word index of the first valid instruction in the first line after a redirect
occupancy  out  OCC_W  lines currently held in the IFQ
ifq_full  out  1  occupancy == DEPTH

Behaviour:
- Reset (async, any time, including mid-request):
  - state = IDLE, fetch_addr = RESET_PC & ~32'hF, occupancy = 0, start_offset = RESET_PC[3:2].
  - All pulse and valid outputs = 0; no outstanding request.
- FSM states:
  - IDLE → REQ unconditionally on the next cycle.
  - REQ: fetch_req = 1, fetch_addr held stable. On cache_ready & fetch_req → WAIT.
  - WAIT: fetch_req = 0.
    - On cache_dout_valid: ifq_wr_en = 1 in the same cycle (combinational from cache_dout_valid & state==WAIT & ~jmp_branch_valid), fetch_addr += 16 (mod 2^32, wraps to 0).
    - Next state is FULL if the post-update occupancy == DEPTH, else REQ.
  - FULL: wait. On line_pop → REQ in the next cycle.
- Credit rule: a request is only issued when occupancy + outstanding < DEPTH, so fetch_req is never high while full.
- Occupancy update: +1 on ifq_wr_en, −1 on line_pop.
  - Both in the same cycle → unchanged.
  - line_pop while occupancy == 0 → ignored; counter stays 0.
  - ifq_full is combinational from occupancy.
- Redirect (jmp_branch_valid sampled high; overrides every other event that cycle):
  - ifq_wr_en forced 0 that cycle; a same-cycle cache_dout_valid and line_pop are discarded.
  - Registered, next cycle:
    - ifq_flush = 1.
    - cache_abort = 1 only if the state was WAIT (or REQ with cache_ready high).
    - occupancy = 0.
    - fetch_addr = {addr[31:4], 4'b0}, start_offset = addr[3:2].
    - state = REQ.
  - After cache_abort, the cache delivers no data for the cancelled request.
  - Back-to-back redirects: the latest one wins; flush and abort re-pulse.
- start_offset is held until the next redirect.
- fetch_addr only changes on redirect or on an accepted fill; it never changes during REQ.

Optional Feature:
IFQ_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_redirect_cnt[31:0].
  - perf_stall_cnt: +1 per cycle in FULL, or in REQ with cache_ready low.
  - perf_redirect_cnt: +1 per redirect.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, cache_ready=1, each fill one cycle after accept → fetch_addr sequence 0x00400000, 0x00400010, 0x00400020, 0x00400030; occupancy goes 1..4; ifq_full=1; fetch_req=0 in FULL.
- Full queue, then one line_pop → occupancy 3; fetch_req high the next cycle with fetch_addr 0x00400040.
- Branch to 0x00401238 while in WAIT → next cycle ifq_flush=1, cache_abort=1, occupancy=0, fetch_addr=0x00401230, start_offset=2'b10.
- cache_dout_valid and jmp_branch_valid in the same cycle → ifq_wr_en=0; occupancy=0 after the flush; no abort (state leaves WAIT via the fill).
- ifq_wr_en and line_pop in the same cycle at occupancy 2 → occupancy stays 2; line_pop at occupancy 0 → stays 0.
- fetch_addr 0xFFFFFFF0 fill → wraps to 0x00000000; async reset asserted mid-WAIT → all outputs return to reset values immediately.
